// File: rtl/alu_bist_if.sv
// Shared ALU word/opcode types and the ALU interface used by alu_bist.
package alu_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

interface aluif;
    import alu_pkg::*;

    word_t  portA;
    word_t  portB;
    aluop_t aluop;
    word_t  output_port;
    logic   negative;
    logic   overflow;
    logic   zero;

    modport alu_tb (
        output portA, portB, aluop,
        input  output_port, negative, overflow, zero
    );

    modport alu (
        input  portA, portB, aluop,
        output output_port, negative, overflow, zero
    );
endinterface

// File: rtl/alu_bist.sv
// Built-in self-test engine: drives LFSR operands through every ALU op and checks the results.
// Optional: define ALU_BIST_STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module alu_bist
    import alu_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 1024,
    parameter logic [31:0] SEED        = 32'hACE1_1234,
    parameter int unsigned ALU_LATENCY = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] fail_idx,
    aluif.alu_tb        alu_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
    localparam logic [31:0] SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [3:0]  SETTLE_INIT = 4'((ALU_LATENCY == 0) ? 0 : ALU_LATENCY - 1);

    function automatic word_t lfsr_next(input word_t s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    word_t       r_lfsr;
    word_t       r_port_a;
    word_t       r_port_b;
    aluop_t      r_aluop;
    logic [15:0] r_idx;
    logic [3:0]  r_settle_cnt;
    logic [15:0] r_err_count;
    logic [15:0] r_fail_idx;

    logic        w_restart;
    logic        w_load;
    logic        w_stop;
    logic        w_mismatch;
    word_t       w_src_a;
    word_t       w_src_b;
    aluop_t      w_op_next;
    word_t       w_sum;
    word_t       w_diff;
    word_t       w_gold_res;
    logic        w_gold_ovf;

    // Golden model, evaluated on the operands currently driven to the ALU.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_gold_res = '0;
        w_gold_ovf = 1'b0;
        w_sum      = r_port_a + r_port_b;
        w_diff     = r_port_a - r_port_b;
        case (r_aluop)
            ALU_SLL:  w_gold_res = r_port_a << r_port_b[4:0];
            ALU_SRL:  w_gold_res = r_port_a >> r_port_b[4:0];
            ALU_ADD: begin
                w_gold_res = w_sum;
                w_gold_ovf = (r_port_a[31] == r_port_b[31]) && (w_sum[31] != r_port_a[31]);
            end
            ALU_SUB: begin
                w_gold_res = w_diff;
                w_gold_ovf = (r_port_a[31] != r_port_b[31]) && (w_diff[31] != r_port_a[31]);
            end
            ALU_AND:  w_gold_res = r_port_a & r_port_b;
            ALU_OR:   w_gold_res = r_port_a | r_port_b;
            ALU_XOR:  w_gold_res = r_port_a ^ r_port_b;
            ALU_NOR:  w_gold_res = ~(r_port_a | r_port_b);
            ALU_SLT:  w_gold_res = {31'd0, $signed(r_port_a) < $signed(r_port_b)};
            ALU_SLTU: w_gold_res = {31'd0, r_port_a < r_port_b};
            default:  w_gold_res = '0;
        endcase
    end

    assign w_mismatch = (alu_if.output_port != w_gold_res)
                     || (alu_if.negative    != w_gold_res[31])
                     || (alu_if.zero        != (w_gold_res == '0))
                     || (alu_if.overflow    != w_gold_ovf);

`ifdef ALU_BIST_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_restart    = 1'b1;
                    w_load       = 1'b1;
                end
            end
            S_LOAD:   w_state_next = (ALU_LATENCY > 0) ? S_SETTLE : S_CHECK;
            S_SETTLE: if (r_settle_cnt == 4'd0) w_state_next = S_CHECK;
            S_CHECK: begin
                if (w_stop || (r_idx == LAST_IDX)) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_LOAD;
                    w_load       = 1'b1;
                end
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    // A restart takes operands straight from the seed, so vector 0 is on the ports in the first LOAD cycle.
    assign w_src_a   = w_restart ? SEED_EFF : r_lfsr;
    assign w_src_b   = lfsr_next(w_src_a);
    assign w_op_next = w_restart ? ALU_SLL
                     : (r_aluop == ALU_SLTU) ? ALU_SLL : aluop_t'(r_aluop + 4'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_lfsr       <= SEED_EFF;
            r_port_a     <= '0;
            r_port_b     <= '0;
            r_aluop      <= ALU_SLL;
            r_idx        <= '0;
            r_settle_cnt <= '0;
            r_err_count  <= '0;
            r_fail_idx   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            r_state <= w_state_next;

            if (w_load) begin
                r_port_a <= w_src_a;
                r_port_b <= w_src_b;
                r_lfsr   <= lfsr_next(w_src_b);
                r_aluop  <= w_op_next;
            end

            if (w_restart) begin
                r_idx       <= '0;
                r_err_count <= '0;
                r_fail_idx  <= '0;
            end else if (r_state == S_CHECK) begin
                if (w_load) r_idx <= r_idx + 16'd1;
                if (w_mismatch) begin
                    if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                    if (r_err_count == 16'd0)    r_fail_idx  <= r_idx;
                end
            end

            if (r_state == S_LOAD) begin
                r_settle_cnt <= SETTLE_INIT;
            end else if ((r_state == S_SETTLE) && (r_settle_cnt != 4'd0)) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end
        end
    end

    assign busy      = (r_state == S_LOAD) || (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done      = (r_state == S_DONE);
    assign pass      = done && (r_err_count == 16'd0);
    assign err_count = r_err_count;
    assign fail_idx  = r_fail_idx;

    assign alu_if.portA = r_port_a;
    assign alu_if.portB = r_port_b;
    assign alu_if.aluop = r_aluop;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: a behavioural ALU with fault injection plus a vector-list model.
module tb_alu_bist;
    import alu_pkg::*;

    localparam int          N_A    = 20;
    localparam logic [31:0] SEED_A = 32'd1;
    localparam int          N_B    = 5;
    localparam int          LAT_B  = 2;

    typedef struct packed {
        word_t res;
        logic  neg;
        logic  ovf;
        logic  zero;
    } alu_out_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0] err_a, fidx_a, err_b, fidx_b;

    int n_checks = 0;
    int n_errors = 0;

    aluif if_a ();
    aluif if_b ();

    always #5 CLK = ~CLK;

    alu_bist #(.NUM_VECTORS(N_A), .SEED(SEED_A), .ALU_LATENCY(0)) u_dut_a (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start_a),
        .busy      (busy_a),
        .done      (done_a),
        .pass      (pass_a),
        .err_count (err_a),
        .fail_idx  (fidx_a),
        .alu_if    (if_a)
    );

    alu_bist #(.NUM_VECTORS(N_B), .SEED(32'd0), .ALU_LATENCY(LAT_B)) u_dut_b (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start_b),
        .busy      (busy_b),
        .done      (done_b),
        .pass      (pass_b),
        .err_count (err_b),
        .fail_idx  (fidx_b),
        .alu_if    (if_b)
    );

    function automatic alu_out_t alu_ref(input word_t a, input word_t b, input aluop_t op);
        alu_out_t    o;
        logic [32:0] wide;
        o    = '0;
        wide = '0;
        case (op)
            ALU_SLL:  o.res = a << b[4:0];
            ALU_SRL:  o.res = a >> b[4:0];
            ALU_ADD: begin
                wide  = {a[31], a} + {b[31], b};
                o.res = wide[31:0];
                o.ovf = wide[32] ^ wide[31];
            end
            ALU_SUB: begin
                wide  = {a[31], a} - {b[31], b};
                o.res = wide[31:0];
                o.ovf = wide[32] ^ wide[31];
            end
            ALU_AND:  o.res = a & b;
            ALU_OR:   o.res = a | b;
            ALU_XOR:  o.res = a ^ b;
            ALU_NOR:  o.res = ~(a | b);
            ALU_SLT:  o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: o.res = (a < b) ? 32'd1 : 32'd0;
            default:  o.res = '0;
        endcase
        o.neg  = o.res[31];
        o.zero = (o.res == 32'd0);
        return o;
    endfunction

    function automatic word_t lfsr_step(input word_t s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Expected vector list for DUT A, and per-vector fault masks for its ALU.
    word_t       vec_pa [N_A];
    word_t       vec_pb [N_A];
    bit          corrupt_on [N_A];
    logic [34:0] corrupt_mask [N_A];
    logic        fault_add = 1'b0;
    alu_out_t    alu_a;

    always_comb begin
        alu_a = alu_ref(if_a.portA, if_a.portB, if_a.aluop);
        if (fault_add && (if_a.aluop == ALU_ADD)) alu_a.res[0] = ~alu_a.res[0];
        for (int i = 0; i < N_A; i++) begin
            if (corrupt_on[i] && (if_a.portA == vec_pa[i])) alu_a = alu_a ^ corrupt_mask[i];
        end
    end

    assign if_a.output_port = alu_a.res;
    assign if_a.negative    = alu_a.neg;
    assign if_a.overflow    = alu_a.ovf;
    assign if_a.zero        = alu_a.zero;

    // DUT B's ALU answers two cycles after its operands change.
    alu_out_t pipe1, pipe2;
    always @(posedge CLK) begin
        pipe1 <= alu_ref(if_b.portA, if_b.portB, if_b.aluop);
        pipe2 <= pipe1;
    end

    assign if_b.output_port = pipe2.res;
    assign if_b.negative    = pipe2.neg;
    assign if_b.overflow    = pipe2.ovf;
    assign if_b.zero        = pipe2.zero;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "/flags"}, {busy_a, done_a, pass_a}, 3'b000);
        check({tag, "/err"},   err_a, 16'd0);
        check({tag, "/fidx"},  fidx_a, 16'd0);
        check({tag, "/ops"},   {if_a.portA, if_a.portB, 4'(if_a.aluop)}, {32'd0, 32'd0, 4'(ALU_SLL)});
    endtask

    task automatic clear_faults();
        fault_add = 1'b0;
        for (int i = 0; i < N_A; i++) begin
            corrupt_on[i]   = 1'b0;
            corrupt_mask[i] = '0;
        end
    endtask

    // One run on DUT A: operands checked every cycle, a stray start pulsed mid-run, results at done.
    task automatic run_a(input string tag, input int exp_err, input int exp_fidx, input int exp_cycles);
        int cycle;
        int mid;
        int k;
        mid     = int'($urandom_range(exp_cycles - 1, 2));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cycle   = 1;
        check({tag, "/v0"}, {if_a.portA, if_a.portB, 4'(if_a.aluop)}, {SEED_A, 32'd3, 4'(ALU_SLL)});
        while (!done_a && (cycle < 400)) begin
            k = (cycle - 1) / 2;
            if (k < N_A) begin
                check({tag, "/ops"}, {busy_a, if_a.portA, if_a.portB, 4'(if_a.aluop)},
                      {1'b1, vec_pa[k], vec_pb[k], 4'(k % 10)});
            end
            start_a = (cycle == mid);
            tick();
            cycle++;
        end
        start_a = 1'b0;
        check({tag, "/done_cycle"}, cycle, exp_cycles);
        check({tag, "/flags"}, {busy_a, done_a, pass_a}, {1'b0, 1'b1, (exp_err == 0)});
        check({tag, "/err"},  err_a, exp_err);
        check({tag, "/fidx"}, fidx_a, exp_fidx);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        if (exp_err > 0) begin
            check({tag, "/held"}, {if_a.portA, 4'(if_a.aluop)}, {vec_pa[exp_fidx], 4'(exp_fidx % 10)});
        end
`endif
    endtask

    initial begin
        word_t s;
        int    m;
        int    idx;
        int    min_idx;
        int    cycle;

        s = SEED_A;
        for (int i = 0; i < N_A; i++) begin
            vec_pa[i] = s;
            vec_pb[i] = lfsr_step(s);
            s         = lfsr_step(vec_pb[i]);
        end
        clear_faults();

        // Reset values, held in reset and after release.
        repeat (3) tick();
        check_reset_a("rst_hold");
        check("rst_hold_b", {busy_b, done_b, pass_b, err_b, fidx_b}, '0);
        RST = 1'b0;
        tick();
        check_reset_a("rst_idle");

        run_a("clean", 0, 0, 2 * N_A + 1);

        fault_add = 1'b1;
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        run_a("fault_add", 1, 2, 7);
`else
        run_a("fault_add", 2, 2, 2 * N_A + 1);
`endif
        fault_add = 1'b0;

        // Random fault sets: a random bit of a random handful of vectors is flipped.
        for (int r = 0; r < 4; r++) begin
            clear_faults();
            m       = int'($urandom_range(3, 0));
            min_idx = N_A;
            for (int j = 0; j < m; j++) begin
                do idx = int'($urandom_range(N_A - 1, 0)); while (corrupt_on[idx]);
                corrupt_on[idx]   = 1'b1;
                corrupt_mask[idx] = 35'd1 << $urandom_range(34, 0);
                if (idx < min_idx) min_idx = idx;
            end
`ifdef ALU_BIST_STOP_ON_FAIL_EN
            if (m > 0) run_a($sformatf("rand%0d", r), 1, min_idx, 2 * min_idx + 3);
            else       run_a($sformatf("rand%0d", r), 0, 0, 2 * N_A + 1);
`else
            run_a($sformatf("rand%0d", r), m, (m > 0) ? min_idx : 0, 2 * N_A + 1);
`endif
        end
        clear_faults();

        // Asynchronous reset in the LOAD cycle of vector 7.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (14) tick();
        check("mid_v7", {busy_a, if_a.portA}, {1'b1, vec_pa[7]});
        #2 RST = 1'b1;
        #1 check_reset_a("rst_async");
        tick();
        tick();
        RST = 1'b0;
        tick();
        check_reset_a("rst_after");
        run_a("fresh", 0, 0, 2 * N_A + 1);

        // Settle latency: seed 0 falls back to 1, ALU answers two cycles late.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cycle   = 1;
        check("lat_v0", {busy_b, if_b.portA, if_b.portB, 4'(if_b.aluop)}, {1'b1, 32'd1, 32'd3, 4'(ALU_SLL)});
        while (!done_b && (cycle < 200)) begin
            tick();
            cycle++;
        end
        check("lat_done_cycle", cycle, N_B * (2 + LAT_B) + 1);
        check("lat_flags", {busy_b, done_b, pass_b}, 3'b011);
        check("lat_err", err_b, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
